// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with load-use stall and
// branch-flush generation and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_in,
    input  logic             pc_src_e,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [4:0]       rs_1d,
    input  logic [4:0]       rs_2d,
    input  logic [4:0]       rd_d,
    input  logic [3:0]       alu_ctrl_d,
    input  logic [1:0]       result_src_d,
    input  logic             alu_src_d,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             mem_read_d,
    input  logic             branch_d,
    input  logic             jump_d,
    output logic             valid_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [4:0]       rs_1e,
    output logic [4:0]       rs_2e,
    output logic [4:0]       rd_e,
    output logic [3:0]       alu_ctrl_e,
    output logic [1:0]       result_src_e,
    output logic             alu_src_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             mem_read_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] bubble_count
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pc_plus4;
    logic [XLEN-1:0]  r_rd1;
    logic [XLEN-1:0]  r_rd2;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs_1;
    logic [4:0]       r_rs_2;
    logic [4:0]       r_rd;
    logic [3:0]       r_alu_ctrl;
    logic [1:0]       r_result_src;
    logic             r_alu_src;
    logic             r_reg_write;
    logic             r_mem_write;
    logic             r_mem_read;
    logic             r_branch;
    logic             r_jump;
    logic [CNT_W-1:0] r_bubble_count;

    logic w_lu_hazard;
    logic w_flush;
    logic w_insert_bubble;
    logic w_cnt_sat;

    // A redirect from EX kills the dependent instruction anyway, so it masks the stall.
    assign w_lu_hazard = ~rst & r_valid & r_mem_read & (r_rd != 5'd0) & valid_d
                       & ((r_rd == rs_1d) | (r_rd == rs_2d)) & ~pc_src_e;
    assign w_flush         = ~rst & pc_src_e;
    assign w_insert_bubble = w_lu_hazard | w_flush;
    assign w_cnt_sat       = &r_bubble_count;

    assign stall_f = w_lu_hazard;
    assign stall_d = w_lu_hazard;
    assign flush_d = w_flush;

    always_ff @(posedge clk) begin
        if (rst || (!hold_in && w_insert_bubble)) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_pc_plus4   <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs_1       <= '0;
            r_rs_2       <= '0;
            r_rd         <= '0;
            r_alu_ctrl   <= '0;
            r_result_src <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
        end else if (!hold_in) begin
            r_valid      <= valid_d;
            r_pc         <= pc_d;
            r_pc_plus4   <= pc_plus4_d;
            r_rd1        <= rd1_d;
            r_rd2        <= rd2_d;
            r_imm        <= imm_d;
            r_rs_1       <= rs_1d;
            r_rs_2       <= rs_2d;
            r_rd         <= rd_d;
            r_alu_ctrl   <= alu_ctrl_d;
            r_result_src <= result_src_d;
            r_alu_src    <= alu_src_d;
            r_reg_write  <= reg_write_d;
            r_mem_write  <= mem_write_d;
            r_mem_read   <= mem_read_d;
            r_branch     <= branch_d;
            r_jump       <= jump_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_count <= '0;
        end else if (!hold_in && w_insert_bubble && !w_cnt_sat) begin
            r_bubble_count <= r_bubble_count + 1'b1;
        end
    end

    assign valid_e      = r_valid;
    assign pc_e         = r_pc;
    assign pc_plus4_e   = r_pc_plus4;
    assign rd1_e        = r_rd1;
    assign rd2_e        = r_rd2;
    assign imm_e        = r_imm;
    assign rs_1e        = r_rs_1;
    assign rs_2e        = r_rs_2;
    assign rd_e         = r_rd;
    assign alu_ctrl_e   = r_alu_ctrl;
    assign result_src_e = r_result_src;
    assign alu_src_e    = r_alu_src;
    assign reg_write_e  = r_reg_write;
    assign mem_write_e  = r_mem_write;
    assign mem_read_e   = r_mem_read;
    assign branch_e     = r_branch;
    assign jump_e       = r_jump;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a per-edge reference
// model of the EX-stage contents, hazard outputs and bubble counter.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CW   = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic [1:0]  result_src;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        jump;
    } stage_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    hold;
    logic    pc_src;
    stage_t  din;

    logic             valid_e;
    logic [XLEN-1:0]  pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
    logic [4:0]       rs_1e, rs_2e, rd_e;
    logic [3:0]       alu_ctrl_e;
    logic [1:0]       result_src_e;
    logic             alu_src_e, reg_write_e, mem_write_e, mem_read_e, branch_e, jump_e;
    logic             stall_f, stall_d, flush_d;
    logic [CW-1:0]    bubble_count;
    stage_t           dut_e;

    stage_t        m;
    logic [CW-1:0] m_cnt;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hold_in(hold), .pc_src_e(pc_src),
        .valid_d(din.valid), .pc_d(din.pc), .pc_plus4_d(din.pc4),
        .rd1_d(din.rd1), .rd2_d(din.rd2), .imm_d(din.imm),
        .rs_1d(din.rs1), .rs_2d(din.rs2), .rd_d(din.rd),
        .alu_ctrl_d(din.alu_ctrl), .result_src_d(din.result_src),
        .alu_src_d(din.alu_src), .reg_write_d(din.reg_write),
        .mem_write_d(din.mem_write), .mem_read_d(din.mem_read),
        .branch_d(din.branch), .jump_d(din.jump),
        .valid_e(valid_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .rs_1e(rs_1e), .rs_2e(rs_2e), .rd_e(rd_e),
        .alu_ctrl_e(alu_ctrl_e), .result_src_e(result_src_e),
        .alu_src_e(alu_src_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .mem_read_e(mem_read_e),
        .branch_e(branch_e), .jump_e(jump_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .bubble_count(bubble_count)
    );

    assign dut_e = {valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs_1e, rs_2e, rd_e,
                    alu_ctrl_e, result_src_e, alu_src_e, reg_write_e, mem_write_e,
                    mem_read_e, branch_e, jump_e};

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check hazard outputs for the current inputs, clock, then check EX state.
    task automatic step(input string tag);
        logic exp_lu;
        logic exp_fl;
        #1;
        exp_fl = !rst && pc_src;
        exp_lu = !rst && m.valid && m.mem_read && (m.rd != 0) && din.valid
                 && ((m.rd == din.rs1) || (m.rd == din.rs2)) && !pc_src;
        check({tag, ".stall_f"}, stall_f, exp_lu);
        check({tag, ".stall_d"}, stall_d, exp_lu);
        check({tag, ".flush_d"}, flush_d, exp_fl);
        @(posedge clk);
        if (rst) begin
            m     = '0;
            m_cnt = '0;
        end else if (hold) begin
            m = m;
        end else if (exp_lu || exp_fl) begin
            m = '0;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
        end else begin
            m = din;
        end
        #1;
        check({tag, ".ex"}, dut_e, m);
        check({tag, ".bubble_count"}, bubble_count, m_cnt);
        $display("[TB] %s: pc_src=%0b hold=%0b stall=%0b valid_e=%0b rd_e=%0d cnt=%0d",
                 tag, pc_src, hold, exp_lu, valid_e, rd_e, bubble_count);
    endtask

    function automatic stage_t lw(input logic [4:0] rd);
        stage_t s;
        s = '0;
        s.valid = 1'b1; s.pc = 32'h200; s.pc4 = 32'h204; s.rd1 = 32'h1000;
        s.imm = 32'h8; s.rs1 = 5'd2; s.rd = rd; s.alu_src = 1'b1;
        s.reg_write = 1'b1; s.mem_read = 1'b1; s.result_src = 2'b01;
        return s;
    endfunction

    function automatic stage_t add(input logic [4:0] rs1, input logic [4:0] rs2, input logic v);
        stage_t s;
        s = '0;
        s.valid = v; s.pc = 32'h204; s.pc4 = 32'h208; s.rd1 = 32'h11; s.rd2 = 32'h22;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = 5'd7; s.reg_write = 1'b1; s.alu_ctrl = 4'd0;
        return s;
    endfunction

    initial begin
        m = '0; m_cnt = '0; hold = 1'b0; pc_src = 1'b0;

        // Reset with busy, nonzero decode inputs.
        rst = 1'b1;
        din = '1;
        step("reset0");
        step("reset1");
        check("reset.valid_e", valid_e, 1'b0);
        check("reset.count", bubble_count, '0);
        rst = 1'b0;

        // Plain capture.
        din = '0;
        din.valid = 1'b1; din.pc = 32'h100; din.rd1 = 32'hDEADBEEF; din.rd = 5'd5; din.reg_write = 1'b1;
        step("capture");
        check("capture.pc_e", pc_e, 32'h100);
        check("capture.rd1_e", rd1_e, 32'hDEADBEEF);
        check("capture.rd_e", rd_e, 5'd5);

        // Load-use: exactly one bubble, then the dependent add enters EX.
        din = lw(5'd5);
        step("lu.load");
        din = add(5'd3, 5'd5, 1'b1);
        step("lu.stall");
        check("lu.bubble_valid", valid_e, 1'b0);
        check("lu.bubble_regwrite", reg_write_e, 1'b0);
        check("lu.count", bubble_count, 4'd1);
        step("lu.release");
        check("lu.add_rs2", rs_2e, 5'd5);

        // x0 destination and invalid decode slots never stall.
        din = lw(5'd0);
        step("x0.load");
        din = add(5'd0, 5'd0, 1'b1);
        step("x0.add");
        check("x0.captured", valid_e, 1'b1);
        din = lw(5'd5);
        step("inv.load");
        din = add(5'd5, 5'd5, 1'b0);
        step("inv.add");
        check("inv.captured_rs1", rs_1e, 5'd5);
        check("inv.count", bubble_count, 4'd1);

        // Branch flush while load-use is also true: flush wins, one bubble.
        din = lw(5'd5);
        step("br.load");
        din = add(5'd5, 5'd1, 1'b1);
        pc_src = 1'b1;
        step("br.flush");
        pc_src = 1'b0;
        check("br.count", bubble_count, 4'd2);

        // Hold for three cycles with a live hazard and toggling decode inputs.
        din = lw(5'd5);
        step("hold.load");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = add(5'd5, 5'(i), 1'b1);
            din.imm = $urandom;
            step("hold.frozen");
        end
        check("hold.rd_e", rd_e, 5'd5);
        hold = 1'b0;
        step("hold.release");
        check("hold.count", bubble_count, 4'd3);
        step("hold.after");

        // Saturation of the narrow counter.
        pc_src = 1'b1;
        for (int i = 0; i < 16; i++) step("sat");
        check("sat.count", bubble_count, 4'hF);
        pc_src = 1'b0;

        // Randomized traffic biased toward register-address collisions.
        for (int i = 0; i < 300; i++) begin
            din.valid      = ($urandom_range(0, 3) != 0);
            din.pc         = $urandom;
            din.pc4        = $urandom;
            din.rd1        = $urandom;
            din.rd2        = $urandom;
            din.imm        = $urandom;
            din.rs1        = 5'($urandom_range(0, 3));
            din.rs2        = 5'($urandom_range(0, 3));
            din.rd         = 5'($urandom_range(0, 3));
            din.alu_ctrl   = 4'($urandom);
            din.result_src = 2'($urandom);
            din.alu_src    = 1'($urandom);
            din.reg_write  = 1'($urandom);
            din.mem_write  = 1'($urandom);
            din.mem_read   = 1'($urandom);
            din.branch     = 1'($urandom);
            din.jump       = 1'($urandom);
            pc_src = ($urandom_range(0, 5) == 0);
            hold   = ($urandom_range(0, 6) == 0);
            rst    = ($urandom_range(0, 60) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32I 5-stage core, combined with load-use and control-hazard stall/flush generation.
- Captures decoded operands and control from the decode stage.
- Presents the EX-stage fields, including rs_1e/rs_2e consumed by the forwarding unit.
- Produces stall_f/stall_d/flush_d for IF and IF/ID, and inserts bubbles into EX.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of pc, rd1, rd2 and imm.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-high
- hold_in  in  1  global freeze (e.g. memory wait); register contents retained
- pc_src_e  in  1  taken branch/jump resolved in EX this cycle
- valid_d  in  1  decode stage holds a real instruction
- pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d  in  XLEN  decode data fields
- rs_1d, rs_2d, rd_d  in  5  decode register addresses
- alu_ctrl_d  in  4  ALU operation
- result_src_d  in  2  writeback select (00 ALU, 01 load, 10 pc+4)
- alu_src_d, reg_write_d, mem_write_d, mem_read_d, branch_d, jump_d  in  1  decode control bits
- valid_e, and every field above with suffix _e (pc_e, ..., rs_1e, rs_2e, rd_e, ..., jump_e)  out  same widths  registered EX-stage copy
- stall_f  out  1  hold the PC
- stall_d  out  1  hold IF/ID
- flush_d  out  1  clear IF/ID
- bubble_count  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset: every _e output and bubble_count is 0 on the first rising edge with rst=1. rst takes priority over all other inputs.
- Hazard detection (combinational, computed from registered _e state and the current decode inputs):
  - lu_hazard = valid_e & mem_read_e & (rd_e != 0) & valid_d & ((rd_e == rs_1d) | (rd_e == rs_2d)) & ~pc_src_e
  - stall_f = stall_d = lu_hazard
  - flush_d = pc_src_e
  - insert_bubble = lu_hazard | pc_src_e
- All hazard outputs read 0 while rst=1.
- Register update, evaluated per rising edge in priority order:
  1. rst: clear all fields.
  2. hold_in=1: all _e fields and bubble_count unchanged, even if insert_bubble=1.
  3. insert_bubble=1: load a bubble.
     - Bubble: valid_e, reg_write_e, mem_write_e, mem_read_e, branch_e, jump_e, rs_1e, rs_2e, rd_e, alu_ctrl_e, result_src_e and alu_src_e are all 0. Data fields are also 0.
     - bubble_count increments by 1, saturating at all-ones.
  4. Otherwise: capture all _d inputs, with valid_e = valid_d.
- Latency: one cycle from decode inputs to _e outputs.
- Load-use penalty is exactly one bubble. On the following cycle the load has moved to MEM, so lu_hazard deasserts and the dependent instruction enters EX, receiving its operand by writeback-path forwarding.
- pc_src_e together with a load-use condition: the flush wins. lu_hazard is masked, no stall is asserted, and exactly one bubble is counted.
- rs_1d/rs_2d equal to 0 never stalls, because rd_e=0 is excluded.
- A decode slot with valid_d=0 never stalls.
- A decode slot with valid_d=0 is captured normally. It is not counted as a bubble.
- A pc_src_e pulse that coincides with hold_in=1 is not lost: the bubble is inserted on the first edge with hold_in=0, provided pc_src_e is still asserted. The EX stage holds pc_src_e stable during a hold.
- Control bits of a bubble are 0, so it can never write the register file or memory, and it can never redirect the PC.

Test Plan:
- Reset:
  - Stimulus: drive all _d inputs nonzero, assert rst for 2 cycles.
  - Required: all _e outputs = 0, bubble_count = 0, stall_f/stall_d/flush_d = 0.
- Plain capture:
  - Stimulus: valid_d=1, pc_d=0x100, rd1_d=0xDEADBEEF, rd_d=5, reg_write_d=1, no hazards.
  - Required: next cycle pc_e=0x100, rd1_e=0xDEADBEEF, rd_e=5, reg_write_e=1, valid_e=1.
- Load-use:
  - Stimulus: EX holds lw x5 (mem_read_e=1, rd_e=5); decode add with rs_2d=5.
  - Required: stall_f = stall_d = 1 that cycle; next cycle valid_e=0, reg_write_e=0, bubble_count=1; the cycle after, the add is captured with stalls low.
- x0 and invalid decode:
  - Stimulus: same as load-use but rd_e=0, then repeat with rd_e=5 and valid_d=0.
  - Required: no stall in either case; the decode fields are captured.
- Branch flush with simultaneous load-use:
  - Stimulus: pc_src_e=1 while the load-use condition is also true.
  - Required: flush_d=1, stall_f=0, exactly one bubble inserted, bubble_count +1.
- Hold:
  - Stimulus: hold_in=1 for 3 cycles while _d inputs toggle and lu_hazard=1.
  - Required: _e outputs frozen and bubble_count unchanged. On release with the hazard still present, a single bubble is inserted.
  - Also: preset bubble_count to all-ones (force) and insert one more bubble; it stays all-ones.
